// File: rtl/sample_scheduler.sv
// sample_scheduler: per-sample frame sequencer. Each clk_fs rise starts a frame
// that strobes N_CH slots in turn, waits on each done, and checks overruns.
// Ports: clk_256fs/rst (async high); clk_fs/enable frame trigger;
//   ch_start/ch_done slot handshake; busy/active_ch/frame_strobe status;
//   frame_count/cycles_used stats; overrun sticky flag with overrun_clr.
module sample_scheduler #(
  parameter int N_CH   = 4,
  parameter int BUDGET = 240
) (
  input  logic                    clk_256fs,
  input  logic                    rst,
  input  logic                    clk_fs,
  input  logic                    enable,
  output logic [N_CH-1:0]         ch_start,
  input  logic [N_CH-1:0]         ch_done,
  output logic                    busy,
  output logic [$clog2(N_CH)-1:0] active_ch,
  output logic                    frame_strobe,
  output logic [15:0]             frame_count,
  output logic [7:0]              cycles_used,
  output logic                    overrun,
  input  logic                    overrun_clr
);

  localparam int AW = $clog2(N_CH);
  localparam logic [AW-1:0] LAST = AW'(N_CH - 1);
  localparam logic [7:0] BUD = 8'(BUDGET);
  localparam logic [N_CH-1:0] ONE = N_CH'(1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT
  } state_t;

  state_t state, state_n;

  logic fs_q, fs_prev, rise;
  logic [7:0] cyc, cyc_n;

  logic restart, set_ovr, adv, fin;

  logic [N_CH-1:0] ch_start_n;
  logic [AW-1:0] act_n;
  logic busy_n, strobe_n, ovr_n;
  logic [15:0] fc_n;
  logic [7:0] cu_n;

  // Both edge-detect flops reset high so a clk_fs that is
  // already high at reset release is not seen as a rise.
  always_ff @(posedge clk_256fs or posedge rst) begin
    if (rst) begin
      fs_q    <= 1'b1;
      fs_prev <= 1'b1;
    end else begin
      fs_q    <= clk_fs;
      fs_prev <= fs_q;
    end
  end

  assign rise = fs_q & ~fs_prev;

  always_ff @(posedge clk_256fs or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Priority inside a frame: collision, then budget, then done.
  always_comb begin
    state_n = state;
    restart = 1'b0;
    set_ovr = 1'b0;
    adv     = 1'b0;
    fin     = 1'b0;
    unique case (state)
      IDLE: begin
        if (rise && enable) begin
          state_n = START;
          restart = 1'b1;
        end
      end
      START, WAIT: begin
        if (rise) begin
          set_ovr = 1'b1;
          if (enable) begin
            state_n = START;
            restart = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end else if (cyc == BUD) begin
          set_ovr = 1'b1;
          state_n = IDLE;
        end else if (state == START) begin
          state_n = WAIT;
        end else if (ch_done[active_ch]) begin
          if (active_ch != LAST) begin
            adv     = 1'b1;
            state_n = START;
          end else begin
            fin     = 1'b1;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    act_n = active_ch;
    if (restart)  act_n = '0;
    else if (adv) act_n = active_ch + AW'(1);

    ch_start_n = '0;
    if (state_n == START) ch_start_n = ONE << act_n;

    busy_n   = (state_n != IDLE);
    strobe_n = restart;
    fc_n     = frame_count + 16'(restart);
    cu_n     = fin ? cyc : cycles_used;

    ovr_n = overrun;
    if (set_ovr)          ovr_n = 1'b1;
    else if (overrun_clr) ovr_n = 1'b0;

    cyc_n = cyc;
    if (restart)
      cyc_n = '0;
    else if (state != IDLE && cyc != 8'hFF)
      cyc_n = cyc + 8'd1;
  end

  always_ff @(posedge clk_256fs or posedge rst) begin
    if (rst) begin
      ch_start     <= '0;
      active_ch    <= '0;
      busy         <= 1'b0;
      frame_strobe <= 1'b0;
      frame_count  <= '0;
      cycles_used  <= '0;
      overrun      <= 1'b0;
      cyc          <= '0;
    end else begin
      ch_start     <= ch_start_n;
      active_ch    <= act_n;
      busy         <= busy_n;
      frame_strobe <= strobe_n;
      frame_count  <= fc_n;
      cycles_used  <= cu_n;
      overrun      <= ovr_n;
      cyc          <= cyc_n;
    end
  end

endmodule

// File: tb/tb_sample_scheduler.sv
// tb_sample_scheduler: directed scenarios for sample_scheduler.
// Expected output events are queued by stimulus; a monitor checks them.
module tb_sample_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clk_fs = 1'b0;
  logic enable = 1'b0;
  logic overrun_clr = 1'b0;
  logic probe = 1'b0;

  logic [3:0] ch_start, ch_done;
  logic [3:0] resp_q = '0;
  logic [3:0] resp_mask = '0;
  logic [3:0] force_done = '0;
  logic busy, frame_strobe, overrun;
  logic [1:0] active_ch;
  logic [15:0] frame_count;
  logic [7:0] cycles_used;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [3:0]  st;
    logic        fs;
    logic        bz;
    logic [1:0]  ac;
    logic [15:0] fc;
    logic [7:0]  cu;
    logic        ov;
    int          rel;
  } ev_t;

  ev_t exq[$];

  assign ch_done = resp_q | force_done;

  sample_scheduler #(.N_CH(4), .BUDGET(240)) dut (
    .clk_256fs   (clk),
    .rst         (rst),
    .clk_fs      (clk_fs),
    .enable      (enable),
    .ch_start    (ch_start),
    .ch_done     (ch_done),
    .busy        (busy),
    .active_ch   (active_ch),
    .frame_strobe(frame_strobe),
    .frame_count (frame_count),
    .cycles_used (cycles_used),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  initial forever #5 clk = ~clk;

  // Slot model: returns a one-cycle done in the cycle after each
  // start, for the slots enabled in resp_mask.
  initial begin
    logic [3:0] seen;
    forever begin
      @(negedge clk);
      seen = ch_start;
      @(posedge clk);
      #1;
      resp_q = seen & resp_mask;
    end
  end

  function automatic ev_t mk(logic [3:0] st, logic fs, logic bz,
                             int ac, int fc, int cu, logic ov,
                             int rel);
    ev_t e;
    e.st = st; e.fs = fs; e.bz = bz;
    e.ac = 2'(ac); e.fc = 16'(fc); e.cu = 8'(cu);
    e.ov = ov; e.rel = rel;
    return e;
  endfunction

  // Monitor: an event is any start pulse, a busy fall, or a probe.
  initial begin
    logic bprev;
    int rel;
    int n;
    ev_t g, e;
    bprev = 1'b0;
    rel = 0;
    n = 0;
    forever begin
      @(negedge clk);
      if (frame_strobe) rel = 0;
      else rel++;
      if (ch_start != 0 || (bprev && !busy) || probe) begin
        g = mk(ch_start, frame_strobe, busy, int'(active_ch),
               int'(frame_count), int'(cycles_used), overrun, rel);
        tests++;
        if (exq.size() == 0) begin
          fails++;
          $display("FAIL ev%0d unexpected: st=%b fs=%b busy=%b ac=%0d fc=%0d",
                   n, g.st, g.fs, g.bz, g.ac, g.fc);
        end else begin
          e = exq.pop_front();
          if (g.st !== e.st || g.fs !== e.fs || g.bz !== e.bz ||
              g.ac !== e.ac || g.fc !== e.fc || g.cu !== e.cu ||
              g.ov !== e.ov || (e.rel >= 0 && g.rel != e.rel)) begin
            fails++;
            $display("FAIL ev%0d: got st=%b fs=%b busy=%b ac=%0d fc=%0d cu=%0d ov=%b rel=%0d, expected st=%b fs=%b busy=%b ac=%0d fc=%0d cu=%0d ov=%b rel=%0d",
                     n, g.st, g.fs, g.bz, g.ac, g.fc, g.cu, g.ov, g.rel,
                     e.st, e.fs, e.bz, e.ac, e.fc, e.cu, e.ov, e.rel);
          end
        end
        n++;
      end
      bprev = busy;
    end
  end

  task automatic tick(int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic do_probe(ev_t e);
    exq.push_back(e);
    tick(1);
    probe = 1'b1;
    tick(1);
    probe = 1'b0;
  endtask

  // Raise clk_fs, wait for the strobe, drop clk_fs; returns in c1.
  task automatic start_frame();
    bit seen;
    seen = 1'b0;
    tick(1);
    clk_fs = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (frame_strobe) seen = 1'b1;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL start_frame: no frame_strobe within 10 cycles, expected one");
    end
    tick(1);
    clk_fs = 1'b0;
  endtask

  task automatic fs_pulse();
    tick(1);
    clk_fs = 1'b1;
    tick(4);
    clk_fs = 1'b0;
    tick(4);
  endtask

  task automatic push_nominal(int fc, int cu0, int cu1);
    exq.push_back(mk(4'b0001, 1, 1, 0, fc, cu0, 0, 0));
    exq.push_back(mk(4'b0010, 0, 1, 1, fc, cu0, 0, 2));
    exq.push_back(mk(4'b0100, 0, 1, 2, fc, cu0, 0, 4));
    exq.push_back(mk(4'b1000, 0, 1, 3, fc, cu0, 0, 6));
    exq.push_back(mk(4'b0000, 0, 0, 3, fc, cu1, 0, 8));
  endtask

  initial begin
    tick(3);
    rst = 1'b0;
    tick(2);
    do_probe(mk(0, 0, 0, 0, 0, 0, 0, -1));

    // Nominal frame.
    enable = 1'b1;
    resp_mask = 4'hF;
    push_nominal(1, 0, 7);
    start_frame();
    tick(15);

    // Done on slot 3 while slot 0 is awaited.
    resp_mask = 4'b1110;
    force_done = 4'b1000;
    exq.push_back(mk(4'b0001, 1, 1, 0, 2, 7, 0, 0));
    start_frame();
    do_probe(mk(0, 0, 1, 0, 2, 7, 0, 2));
    exq.push_back(mk(4'b0010, 0, 1, 1, 2, 7, 0, 4));
    exq.push_back(mk(4'b0100, 0, 1, 2, 2, 7, 0, 6));
    exq.push_back(mk(4'b1000, 0, 1, 3, 2, 7, 0, 8));
    exq.push_back(mk(4'b0000, 0, 0, 3, 2, 9, 0, 10));
    force_done = 4'b1001;
    tick(1);
    force_done = 4'b1000;
    tick(12);
    force_done = 4'b0000;

    // Budget abort: slot 2 never completes.
    resp_mask = 4'b1011;
    exq.push_back(mk(4'b0001, 1, 1, 0, 3, 9, 0, 0));
    exq.push_back(mk(4'b0010, 0, 1, 1, 3, 9, 0, 2));
    exq.push_back(mk(4'b0100, 0, 1, 2, 3, 9, 0, 4));
    exq.push_back(mk(4'b0000, 0, 0, 2, 3, 9, 1, 241));
    start_frame();
    tick(250);
    do_probe(mk(0, 0, 0, 2, 3, 9, 1, -1));
    overrun_clr = 1'b1;
    tick(1);
    overrun_clr = 1'b0;
    do_probe(mk(0, 0, 0, 2, 3, 9, 0, -1));
    resp_mask = 4'hF;
    push_nominal(4, 9, 7);
    start_frame();
    tick(15);

    // Collision: slot 1 stalls across the next rise.
    resp_mask = 4'b1101;
    exq.push_back(mk(4'b0001, 1, 1, 0, 5, 7, 0, 0));
    exq.push_back(mk(4'b0010, 0, 1, 1, 5, 7, 0, 2));
    start_frame();
    tick(20);
    exq.push_back(mk(4'b0001, 1, 1, 0, 6, 7, 1, 0));
    exq.push_back(mk(4'b0010, 0, 1, 1, 6, 7, 1, 2));
    start_frame();
    tick(20);

    // Rise while busy with enable low ends the frame.
    enable = 1'b0;
    exq.push_back(mk(0, 0, 0, 1, 6, 7, 1, -1));
    fs_pulse();
    fs_pulse();
    fs_pulse();
    fs_pulse();
    do_probe(mk(0, 0, 0, 1, 6, 7, 1, -1));
    overrun_clr = 1'b1;
    tick(1);
    overrun_clr = 1'b0;
    do_probe(mk(0, 0, 0, 1, 6, 7, 0, -1));

    // Clear coincident with a collision: set wins.
    enable = 1'b1;
    exq.push_back(mk(4'b0001, 1, 1, 0, 7, 7, 0, 0));
    exq.push_back(mk(4'b0010, 0, 1, 1, 7, 7, 0, 2));
    start_frame();
    tick(20);
    exq.push_back(mk(4'b0001, 1, 1, 0, 8, 7, 1, 0));
    exq.push_back(mk(4'b0010, 0, 1, 1, 8, 7, 1, 2));
    tick(1);
    clk_fs = 1'b1;
    tick(1);
    overrun_clr = 1'b1;
    tick(1);
    overrun_clr = 1'b0;
    tick(4);
    clk_fs = 1'b0;
    tick(10);

    // Reset mid-wait, clk_fs high at release.
    exq.push_back(mk(0, 0, 0, 0, 0, 0, 0, -1));
    rst = 1'b1;
    clk_fs = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(6);
    do_probe(mk(0, 0, 0, 0, 0, 0, 0, -1));
    clk_fs = 1'b0;
    tick(3);
    resp_mask = 4'hF;
    push_nominal(1, 0, 7);
    start_frame();
    tick(15);

    tests++;
    if (exq.size() != 0) begin
      fails++;
      $display("FAIL leftover: %0d expected events never seen, required 0",
               exq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
